// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and one-hot result decoding for the display paths.
// Segment patterns are active-low with bit 7 as the decimal point (always off here).
package seg7_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_E     = 8'h86;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [3:0] CODE_ERR  = 4'hE;

   // bit9 is digit 0 and bit0 is digit 9, matching the classifier output ordering.
   // Returns {ok, code}; anything other than exactly one set bit yields {0, CODE_ERR}.
   function automatic logic [4:0] onehot_to_code(input logic [9:0] oh);
      logic [3:0] ones;
      logic [3:0] code;
      ones = 4'd0;
      code = CODE_ERR;
      for (int b = 0; b < 10; b++) begin
         if (oh[b]) begin
            ones = ones + 4'd1;
            code = 4'(9 - b);
         end
      end
      if (ones == 4'd1) onehot_to_code = {1'b1, code};
      else              onehot_to_code = {1'b0, CODE_ERR};
   endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational {vld, code} to active-low segment pattern; an empty entry shows blank.
module seg7_encoder
   import seg7_pkg::*;
(
   input  logic       vld,
   input  logic [3:0] code,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (vld) begin
         unique case (code)
            4'd0:     seg = SEG_0;
            4'd1:     seg = SEG_1;
            4'd2:     seg = SEG_2;
            4'd3:     seg = SEG_3;
            4'd4:     seg = SEG_4;
            4'd5:     seg = SEG_5;
            4'd6:     seg = SEG_6;
            4'd7:     seg = SEG_7;
            4'd8:     seg = SEG_8;
            4'd9:     seg = SEG_9;
            CODE_ERR: seg = SEG_E;
            default:  seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seg7_history_scan_ctrl.sv
// Result history (newest on slot 0) time-multiplexed onto the 8-digit bank as {seg, sel} words.
// The HC595 driver samples p_data freely, so SCAN_DIV must exceed one shift-and-latch period.
module seg7_history_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        result_valid,
   input  logic [9:0]  result_onehot,
   input  logic        clear,
   output logic [15:0] p_data,
   output logic        frame_tick,
   output logic [3:0]  count,
   output logic        err_flag
);

   localparam int             DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCAN_DIV - 1);
   localparam logic [2:0]     IDX_LAST = 3'(NUM_DIGITS - 1);
   localparam logic [3:0]     CNT_MAX  = 4'(NUM_DIGITS);

   logic             ent_vld  [NUM_DIGITS];
   logic [3:0]       ent_code [NUM_DIGITS];

   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       idx;
   logic             div_tc;
   logic             wrap_q;

   logic [4:0]       res;
   logic [7:0]       seg_cur;
   logic [7:0]       sel_cur;

   assign res    = onehot_to_code(result_onehot);
   assign div_tc = (div_cnt == '0);

   // clear wins over a same-cycle result; the scan counters are deliberately untouched by it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            ent_vld[i]  <= 1'b0;
            ent_code[i] <= 4'd0;
         end
         count    <= 4'd0;
         err_flag <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            ent_vld[i]  <= 1'b0;
            ent_code[i] <= 4'd0;
         end
         count    <= 4'd0;
         err_flag <= 1'b0;
      end else if (result_valid) begin
         for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            ent_vld[i]  <= ent_vld[i-1];
            ent_code[i] <= ent_code[i-1];
         end
         ent_vld[0]  <= 1'b1;
         ent_code[0] <= res[3:0];
         if (!res[4])
            err_flag <= 1'b1;
         if (count != CNT_MAX)
            count <= count + 4'd1;
      end
   end

   // slot timer counts down; terminal count advances the digit index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= DIV_LOAD;
         idx     <= 3'd0;
      end else if (div_tc) begin
         div_cnt <= DIV_LOAD;
         idx     <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end else begin
         div_cnt <= div_cnt - DIV_W'(1);
      end
   end

   seg7_encoder u_enc (
      .vld  (ent_vld[idx]),
      .code (ent_code[idx]),
      .seg  (seg_cur)
   );

   assign sel_cur = 8'd1 << idx;

   // frame_tick is delayed twice so it lines up with the first p_data word carrying sel=01
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_q     <= 1'b0;
         frame_tick <= 1'b0;
         p_data     <= {SEG_BLANK, 8'h01};
      end else begin
         wrap_q     <= div_tc && (idx == IDX_LAST);
         frame_tick <= wrap_q;
         p_data     <= {seg_cur, sel_cur};
      end
   end

endmodule

// File: tb/tb_seg7_history_scan_ctrl.sv
// Directed bench for seg7_history_scan_ctrl with SCAN_DIV=4, NUM_DIGITS=8.
module tb_seg7_history_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        result_valid = 1'b0;
   logic [9:0]  result_onehot = 10'h000;
   logic        clear = 1'b0;
   logic [15:0] p_data;
   logic        frame_tick;
   logic [3:0]  count;
   logic        err_flag;

   always #5 clk = ~clk;

   seg7_history_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .result_valid  (result_valid),
      .result_onehot (result_onehot),
      .clear         (clear),
      .p_data        (p_data),
      .frame_tick    (frame_tick),
      .count         (count),
      .err_flag      (err_flag)
   );

   typedef struct {
      logic [9:0] onehot;
      logic [7:0] seg0;
      logic [3:0] cnt;
      logic       err;
   } vec_t;

   vec_t       vecs [12];
   logic [7:0] exp_seg [8];
   int         total = 0;
   int         bad = 0;
   int         k = 0;
   bit         chk_seg = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
      end
   endtask

   // k counts clock edges since reset release; p_data after edge k shows idx from edge k-1
   task automatic tick();
      int ix;
      @(posedge clk);
      k++;
      @(negedge clk);
      ix = ((k - 1) / 4) % 8;
      check("sel", {24'd0, p_data[7:0]}, 32'd1 << ix);
      check("frame_tick", {31'd0, frame_tick}, (k > 1 && (k - 1) % 32 == 0) ? 32'd1 : 32'd0);
      if (chk_seg)
         check("seg", {24'd0, p_data[15:8]}, {24'd0, exp_seg[ix]});
   endtask

   task automatic send(input logic [9:0] oh, input logic vld, input logic clr);
      chk_seg       = 1'b0;
      result_onehot = oh;
      result_valid  = vld;
      clear         = clr;
      tick();
      result_valid  = 1'b0;
      clear         = 1'b0;
      tick();
   endtask

   task automatic frame();
      chk_seg = 1'b1;
      repeat (32) tick();
      chk_seg = 1'b0;
   endtask

   task automatic blank_all();
      for (int j = 0; j < 8; j++) exp_seg[j] = 8'hFF;
   endtask

   task automatic apply_vec(input int i);
      int n;
      send(vecs[i].onehot, 1'b1, 1'b0);
      n = 0;
      while (p_data[7:0] != 8'h01 && n < 40) begin
         tick();
         n++;
      end
      check("slot0_wait", {31'd0, (p_data[7:0] == 8'h01)}, 32'd1);
      check("vec_seg0", {24'd0, p_data[15:8]}, {24'd0, vecs[i].seg0});
      check("vec_count", {28'd0, count}, {28'd0, vecs[i].cnt});
      check("vec_err", {31'd0, err_flag}, {31'd0, vecs[i].err});
   endtask

   initial begin
      vecs[0]  = '{10'h200, 8'hC0, 4'd1, 1'b0};
      vecs[1]  = '{10'h100, 8'hF9, 4'd2, 1'b0};
      vecs[2]  = '{10'h080, 8'hA4, 4'd3, 1'b0};
      vecs[3]  = '{10'h040, 8'hB0, 4'd4, 1'b0};
      vecs[4]  = '{10'h020, 8'h99, 4'd5, 1'b0};
      vecs[5]  = '{10'h010, 8'h92, 4'd6, 1'b0};
      vecs[6]  = '{10'h008, 8'h82, 4'd7, 1'b0};
      vecs[7]  = '{10'h004, 8'hF8, 4'd8, 1'b0};
      vecs[8]  = '{10'h002, 8'h80, 4'd8, 1'b0};
      vecs[9]  = '{10'h0C0, 8'h86, 4'd8, 1'b1};
      vecs[10] = '{10'h001, 8'h90, 4'd8, 1'b1};
      vecs[11] = '{10'h000, 8'h86, 4'd8, 1'b1};

      // reset asserted mid-frame with a stored result must discard everything
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      result_onehot = 10'h0C0;
      result_valid  = 1'b1;
      @(negedge clk);
      result_valid  = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_p_data", {16'd0, p_data}, 32'h0000FF01);
      check("rst_count", {28'd0, count}, 32'd0);
      check("rst_err", {31'd0, err_flag}, 32'd0);
      check("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      k = 0;

      // idle scan: first idx step lands on edge 4, visible on edge 5; blank segments
      blank_all();
      chk_seg = 1'b1;
      repeat (40) tick();
      chk_seg = 1'b0;
      check("idle_count", {28'd0, count}, 32'd0);
      check("idle_err", {31'd0, err_flag}, 32'd0);

      // two results: 7 newest on slot 0, 3 on slot 1
      send(10'h040, 1'b1, 1'b0);
      send(10'h004, 1'b1, 1'b0);
      check("hist2_count", {28'd0, count}, 32'd2);
      blank_all();
      exp_seg[0] = 8'hF8;
      exp_seg[1] = 8'hB0;
      frame();

      // fill from empty with digits 0..8: the oldest (0) drops off
      send(10'h000, 1'b0, 1'b1);
      check("clear_count", {28'd0, count}, 32'd0);
      for (int i = 0; i < 9; i++) apply_vec(i);
      for (int j = 0; j < 8; j++) exp_seg[j] = vecs[8 - j].seg0;
      frame();

      // malformed codes set the sticky error; a later good result keeps it
      for (int i = 9; i < 12; i++) apply_vec(i);

      // clear and a result in the same cycle: clear wins, scan phase keeps going
      send(10'h200, 1'b1, 1'b1);
      check("coll_count", {28'd0, count}, 32'd0);
      check("coll_err", {31'd0, err_flag}, 32'd0);
      blank_all();
      frame();

      // result lands on the same edge that idx wraps 7->0
      while ((k + 1) % 32 != 0) tick();
      result_onehot = 10'h010;
      result_valid  = 1'b1;
      tick();
      result_valid  = 1'b0;
      tick();
      check("boundary_p_data", {16'd0, p_data}, 32'h00009201);
      check("boundary_count", {28'd0, count}, 32'd1);
      exp_seg[0] = 8'h92;
      frame();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
